// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two valid/ready requesters
module alu_arbiter (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        r0_valid,
  input  logic        r1_valid,
  output logic        r0_ready,
  output logic        r1_ready,
  input  logic [31:0] r0_portA,
  input  logic [31:0] r0_portB,
  input  logic [31:0] r1_portA,
  input  logic [31:0] r1_portB,
  input  logic [3:0]  r0_aluop,
  input  logic [3:0]  r1_aluop,
  output logic        r0_rvalid,
  output logic        r1_rvalid,
  input  logic        r0_rready,
  input  logic        r1_rready,
  output logic [31:0] rsp_result,
  output logic        rsp_neg,
  output logic        rsp_ovf,
  output logic        rsp_zero,
  output logic [31:0] alu_portA,
  output logic [31:0] alu_portB,
  output logic [3:0]  alu_aluop,
  input  logic [31:0] alu_result,
  input  logic        alu_neg,
  input  logic        alu_ovf,
  input  logic        alu_zero,
  output logic        busy,
  output logic        grant
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic last, any, pick, accept;
  assign any = r0_valid | r1_valid;
  assign pick = (r0_valid & r1_valid) ? ~last : r1_valid;
  assign r0_ready = nRST & (state == IDLE) & any & ~pick;
  assign r1_ready = nRST & (state == IDLE) & any & pick;
  assign r0_rvalid = (state == RESP) & ~grant;
  assign r1_rvalid = (state == RESP) & grant;
  assign accept = grant ? r1_rready : r0_rready;
  assign busy = state != IDLE;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      last <= 1'b1;
      grant <= 1'b0;
      alu_portA <= '0;
      alu_portB <= '0;
      alu_aluop <= '0;
      rsp_result <= '0;
      rsp_neg <= 1'b0;
      rsp_ovf <= 1'b0;
      rsp_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state <= EXEC;
          grant <= pick;
          last <= pick;
          alu_portA <= pick ? r1_portA : r0_portA;
          alu_portB <= pick ? r1_portB : r0_portB;
          alu_aluop <= pick ? r1_aluop : r0_aluop;
        end
        EXEC: begin
          state <= RESP;
          rsp_result <= alu_result;
          rsp_neg <= alu_neg;
          rsp_ovf <= alu_ovf;
          rsp_zero <= alu_zero;
        end
        RESP: if (accept) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
